// File: rtl/mux_n_1_stream_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
// The lock-state enum is only referenced when MUX_N_1_STREAM_PKT_LOCK_EN is defined.
package mux_pkg;

   localparam int MUX_MODE_SEL = 0;
   localparam int MUX_MODE_RR  = 1;

   typedef enum logic {
      LOCK_UNLOCKED = 1'b0,
      LOCK_LOCKED   = 1'b1
   } lock_state_e;

   // Smallest w with 2**w >= value; the loop stops short of the sign bit.
   function automatic int clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mux_n_1_stream_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the rotating pointer,
// and moves the pointer one past the granted channel when 'advance' is high.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter  int N     = 4,
   localparam int SEL_W = clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             advance,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             has_gnt
);

   logic [SEL_W-1:0] ptr_q, ptr_d;
   logic [SEL_W-1:0] cand;

   function automatic logic [SEL_W-1:0] wrapAdd(input logic [SEL_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N) s = s - N;
      return SEL_W'(s);
   endfunction

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      has_gnt = 1'b0;
      cand    = '0;
      for (int k = 0; k < N; k++) begin
         cand = wrapAdd(ptr_q, k);
         if (!has_gnt && req[cand]) begin
            has_gnt    = 1'b1;
            gnt_idx    = cand;
            gnt[cand]  = 1'b1;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && has_gnt) ptr_d = wrapAdd(gnt_idx, 1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mux_n_1_stream.sv
// Registered N:1 valid/ready stream multiplexer with external-select or round-robin choice.
// Optional packet locking (in_last/out_last) is enabled by defining MUX_N_1_STREAM_PKT_LOCK_EN.
module mux_n_1_stream
   import mux_pkg::*;
#(
   parameter  int WIDTH    = 8,
   parameter  int N        = 4,
   parameter  int ARB_MODE = MUX_MODE_SEL,
   localparam int SEL_W    = clog2(N)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SEL_W-1:0]   sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SEL_W-1:0]   grant
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
   ,
   input  logic [N-1:0]       in_last,
   output logic               out_last
`endif
);

   logic [SEL_W-1:0] selEff;
   logic [SEL_W-1:0] chosenIdx;
   logic [N-1:0]     arbReq;
   logic [N-1:0]     chosenOneHot;
   logic             chosenValid;
   logic [WIDTH-1:0] chosenData;
   logic             load;
   logic             xfer;

   logic [WIDTH-1:0] outData_q, outData_d;
   logic             outValid_q, outValid_d;
   logic [SEL_W-1:0] grant_q, grant_d;

`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
   lock_state_e      lockState_q, lockState_d;
   logic [SEL_W-1:0] lockCh_q, lockCh_d;
   logic             chosenLast;
   logic             outLast_q, outLast_d;

   // While locked, only the locked channel may be chosen, whatever sel or the arbiter say.
   always_comb begin
      arbReq = in_valid;
      selEff = sel;
      if (lockState_q == LOCK_LOCKED) begin
         selEff = lockCh_q;
         arbReq = '0;
         for (int i = 0; i < N; i++) begin
            if (SEL_W'(i) == lockCh_q) arbReq[i] = in_valid[i];
         end
      end
   end

   always_comb begin
      lockState_d = lockState_q;
      lockCh_d    = lockCh_q;
      if (xfer) begin
         if (chosenLast) begin
            lockState_d = LOCK_UNLOCKED;
         end else begin
            lockState_d = LOCK_LOCKED;
            lockCh_d    = chosenIdx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lockState_q <= LOCK_UNLOCKED;
         lockCh_q    <= '0;
      end else begin
         lockState_q <= lockState_d;
         lockCh_q    <= lockCh_d;
      end
   end
`else
   assign arbReq = in_valid;
   assign selEff = sel;
`endif

   generate
      if (ARB_MODE == MUX_MODE_RR) begin : g_rr
         logic advance;
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
         assign advance = xfer & chosenLast;
`else
         assign advance = xfer;
`endif
         rr_arbiter #(.N(N)) u_arb (
            .clk     (clk),
            .rst_n   (rst_n),
            .req     (arbReq),
            .advance (advance),
            .gnt     (chosenOneHot),
            .gnt_idx (chosenIdx),
            .has_gnt (chosenValid)
         );
      end else begin : g_sel
         // A select value of N or more decodes to no channel at all.
         always_comb begin
            chosenOneHot = '0;
            for (int i = 0; i < N; i++) begin
               if (SEL_W'(i) == selEff) chosenOneHot[i] = 1'b1;
            end
         end
         assign chosenIdx   = selEff;
         assign chosenValid = |(chosenOneHot & arbReq);
      end
   endgenerate

   always_comb begin
      chosenData = '0;
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
      chosenLast = 1'b0;
`endif
      for (int i = 0; i < N; i++) begin
         if (SEL_W'(i) == chosenIdx) begin
            chosenData = in_data[i*WIDTH +: WIDTH];
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
            chosenLast = in_last[i];
`endif
         end
      end
   end

   assign load     = !outValid_q || out_ready;
   assign xfer     = load && chosenValid;
   assign in_ready = (xfer && rst_n) ? chosenOneHot : '0;

   always_comb begin
      outData_d  = outData_q;
      outValid_d = outValid_q;
      grant_d    = grant_q;
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
      outLast_d  = outLast_q;
`endif
      if (xfer) begin
         outData_d  = chosenData;
         outValid_d = 1'b1;
         grant_d    = chosenIdx;
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
         outLast_d  = chosenLast;
`endif
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outData_q  <= '0;
         outValid_q <= 1'b0;
         grant_q    <= '0;
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
         outLast_q  <= 1'b0;
`endif
      end else begin
         outData_q  <= outData_d;
         outValid_q <= outValid_d;
         grant_q    <= grant_d;
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
         outLast_q  <= outLast_d;
`endif
      end
   end

   assign out_data  = outData_q;
   assign out_valid = outValid_q;
   assign grant     = grant_q;
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
   assign out_last  = outLast_q;
`endif

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Directed bench for mux_n_1_stream: 4-channel select, 4-channel round-robin and 3-channel select builds.
// Packet-lock sequence is exercised when MUX_N_1_STREAM_PKT_LOCK_EN is defined.
module tb_mux_n_1_stream;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   int checkCount = 0;
   int errorCount = 0;

   // 4-channel external select
   logic [31:0] s4Data;
   logic [3:0]  s4Valid, s4Ready;
   logic [1:0]  s4Sel, s4Grant;
   logic [7:0]  s4OutData;
   logic        s4OutValid, s4OutReady;

   // 4-channel round-robin
   logic [31:0] r4Data;
   logic [3:0]  r4Valid, r4Ready;
   logic [1:0]  r4Sel, r4Grant;
   logic [7:0]  r4OutData;
   logic        r4OutValid, r4OutReady;

   // 3-channel external select
   logic [23:0] t3Data;
   logic [2:0]  t3Valid, t3Ready;
   logic [1:0]  t3Sel, t3Grant;
   logic [7:0]  t3OutData;
   logic        t3OutValid, t3OutReady;

`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
   logic [3:0] s4Last, r4Last;
   logic [2:0] t3Last;
   logic       s4OutLast, r4OutLast, t3OutLast;
`endif

   mux_n_1_stream #(.WIDTH(8), .N(4), .ARB_MODE(0)) u_sel4 (
      .clk(clk), .rst_n(rst_n), .in_data(s4Data), .in_valid(s4Valid), .in_ready(s4Ready),
      .sel(s4Sel), .out_data(s4OutData), .out_valid(s4OutValid), .out_ready(s4OutReady),
      .grant(s4Grant)
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
      , .in_last(s4Last), .out_last(s4OutLast)
`endif
   );

   mux_n_1_stream #(.WIDTH(8), .N(4), .ARB_MODE(1)) u_rr4 (
      .clk(clk), .rst_n(rst_n), .in_data(r4Data), .in_valid(r4Valid), .in_ready(r4Ready),
      .sel(r4Sel), .out_data(r4OutData), .out_valid(r4OutValid), .out_ready(r4OutReady),
      .grant(r4Grant)
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
      , .in_last(r4Last), .out_last(r4OutLast)
`endif
   );

   mux_n_1_stream #(.WIDTH(8), .N(3), .ARB_MODE(0)) u_sel3 (
      .clk(clk), .rst_n(rst_n), .in_data(t3Data), .in_valid(t3Valid), .in_ready(t3Ready),
      .sel(t3Sel), .out_data(t3OutData), .out_valid(t3OutValid), .out_ready(t3OutReady),
      .grant(t3Grant)
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
      , .in_last(t3Last), .out_last(t3OutLast)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Drives the 4-channel select instance; values settle before the comb checks.
   task automatic applyStimulus(input logic [1:0] sel, input logic [3:0] valid, input logic outReady);
      s4Sel      = sel;
      s4Valid    = valid;
      s4OutReady = outReady;
      #1;
   endtask

   logic [7:0] rrBytes [4];
   logic [1:0] pairSeq [4];

   initial begin
      rst_n = 1'b0;
      s4Data = 32'h44_A5_22_11; s4Valid = 4'b0100; s4Sel = 2'd2; s4OutReady = 1'b1;
      r4Data = 32'hD3_C2_B1_A0; r4Valid = 4'b0000; r4Sel = 2'd0; r4OutReady = 1'b1;
      t3Data = 24'h33_22_11;    t3Valid = 3'b000;  t3Sel = 2'd0; t3OutReady = 1'b1;
`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
      s4Last = '0; r4Last = '0; t3Last = '0;
`endif
      rrBytes[0] = 8'hA0; rrBytes[1] = 8'hB1; rrBytes[2] = 8'hC2; rrBytes[3] = 8'hD3;
      pairSeq[0] = 2'd0;  pairSeq[1] = 2'd3;  pairSeq[2] = 2'd0;  pairSeq[3] = 2'd3;

      // Reset state, including in_ready held low although a channel is valid and selected
      #2;
      checkOutput("rst out_valid", 32'(s4OutValid), 32'd0);
      checkOutput("rst out_data",  32'(s4OutData),  32'd0);
      checkOutput("rst grant",     32'(s4Grant),    32'd0);
      checkOutput("rst in_ready",  32'(s4Ready),    32'd0);
      stepCycle();
      stepCycle();
      rst_n = 1'b1;

      // Single beat through channel 2
      applyStimulus(2'd2, 4'b0100, 1'b1);
      checkOutput("sel2 in_ready", 32'(s4Ready), 32'b0100);
      stepCycle();
      checkOutput("sel2 out_valid", 32'(s4OutValid), 32'd1);
      checkOutput("sel2 out_data",  32'(s4OutData),  32'hA5);
      checkOutput("sel2 grant",     32'(s4Grant),    32'd2);

      // Backpressure: output frozen while sel wanders and every channel is valid
      s4Data = 32'h44_5A_22_11;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(2'(k), 4'b1111, 1'b0);
         checkOutput("bp in_ready", 32'(s4Ready), 32'd0);
         stepCycle();
         checkOutput("bp out_valid", 32'(s4OutValid), 32'd1);
         checkOutput("bp out_data",  32'(s4OutData),  32'hA5);
         checkOutput("bp grant",     32'(s4Grant),    32'd2);
      end
      applyStimulus(2'd1, 4'b1111, 1'b1);
      checkOutput("bp release in_ready", 32'(s4Ready), 32'b0010);
      stepCycle();
      checkOutput("bp release out_data", 32'(s4OutData), 32'h22);
      checkOutput("bp release grant",    32'(s4Grant),    32'd1);
      checkOutput("bp release valid",    32'(s4OutValid), 32'd1);

      // Drain with no valid input: data and grant hold
      applyStimulus(2'd1, 4'b0000, 1'b1);
      checkOutput("drain in_ready", 32'(s4Ready), 32'd0);
      stepCycle();
      checkOutput("drain out_valid", 32'(s4OutValid), 32'd0);
      checkOutput("drain out_data",  32'(s4OutData),  32'h22);
      checkOutput("drain grant",     32'(s4Grant),    32'd1);

      // Asynchronous reset with a beat in flight
      applyStimulus(2'd3, 4'b1000, 1'b1);
      stepCycle();
      checkOutput("pre-rst out_data", 32'(s4OutData), 32'h44);
      checkOutput("pre-rst grant",    32'(s4Grant),   32'd3);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst out_valid", 32'(s4OutValid), 32'd0);
      checkOutput("midrst out_data",  32'(s4OutData),  32'd0);
      checkOutput("midrst grant",     32'(s4Grant),    32'd0);
      checkOutput("midrst in_ready",  32'(s4Ready),    32'd0);
      stepCycle();
      rst_n = 1'b1;
      applyStimulus(2'd0, 4'b0000, 1'b1);

      // Round-robin with every channel valid: 0,1,2,3,0,1,2,3
      r4Valid = 4'b1111;
      #1;
      checkOutput("rr first in_ready", 32'(r4Ready), 32'b0001);
      for (int k = 0; k < 8; k++) begin
         stepCycle();
         checkOutput("rr all grant", 32'(r4Grant),    32'(k % 4));
         checkOutput("rr all data",  32'(r4OutData),  32'(rrBytes[k % 4]));
         checkOutput("rr all valid", 32'(r4OutValid), 32'd1);
      end
      r4Valid = 4'b1001;
      for (int k = 0; k < 4; k++) begin
         stepCycle();
         checkOutput("rr pair grant", 32'(r4Grant),    32'(pairSeq[k]));
         checkOutput("rr pair valid", 32'(r4OutValid), 32'd1);
      end
      r4Valid = 4'b0000;
      stepCycle();
      checkOutput("rr drain valid", 32'(r4OutValid), 32'd0);

      // Three channels: sel=3 selects nothing
      t3Valid = 3'b111; t3Sel = 2'd1;
      #1;
      checkOutput("n3 sel1 in_ready", 32'(t3Ready), 32'b010);
      stepCycle();
      checkOutput("n3 sel1 grant", 32'(t3Grant),   32'd1);
      checkOutput("n3 sel1 data",  32'(t3OutData), 32'h22);
      t3Sel = 2'd3;
      #1;
      checkOutput("n3 sel3 in_ready", 32'(t3Ready), 32'b000);
      stepCycle();
      checkOutput("n3 sel3 out_valid", 32'(t3OutValid), 32'd0);
      checkOutput("n3 sel3 grant",     32'(t3Grant),    32'd1);
      t3Valid = 3'b000;

`ifdef MUX_N_1_STREAM_PKT_LOCK_EN
      // Packet lock in round-robin: channel 1 keeps the output for three beats
      r4Valid = 4'b0010; r4Last = 4'b0000;
      stepCycle();
      checkOutput("lock b1 grant", 32'(r4Grant),   32'd1);
      checkOutput("lock b1 last",  32'(r4OutLast), 32'd0);
      r4Valid = 4'b0111;
      stepCycle();
      checkOutput("lock b2 grant", 32'(r4Grant),   32'd1);
      checkOutput("lock b2 last",  32'(r4OutLast), 32'd0);
      r4Last = 4'b0010;
      stepCycle();
      checkOutput("lock b3 grant", 32'(r4Grant),   32'd1);
      checkOutput("lock b3 last",  32'(r4OutLast), 32'd1);
      r4Valid = 4'b0101; r4Last = 4'b0000;
      stepCycle();
      checkOutput("lock next grant", 32'(r4Grant),   32'd2);
      checkOutput("lock next last",  32'(r4OutLast), 32'd0);
      r4Valid = 4'b0000;
`endif

      stepCycle();
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
